issue_scoreboard: RTL

//  Sits between the decode pipeline register and datapath issue. Tracks which regfile entries

---
 rtl/cesel_pkg.sv | 29 ++
 rtl/issue_scoreboard.sv | 104 ++++++++++
 2 files changed

// File: rtl/cesel_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : cesel_pkg                                              |
// | Shared scheduler types: regfile width, FSM states, decoded op.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package cesel_pkg;

  localparam int REGFILE_ADDR_BITS = 4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } sched_state_e;

  // Field layout mirrors the decode stage outputs.
  typedef struct packed {
    logic [REGFILE_ADDR_BITS-1:0] read1_addr;
    logic [REGFILE_ADDR_BITS-1:0] read2_addr;
    logic [REGFILE_ADDR_BITS-1:0] write_addr;
    logic                         write_en;
    logic                         use_immediate;
    logic                         use_accumulate;
    logic                         halt;
  } decoded_op_t;

endpackage : cesel_pkg
`default_nettype wire

// File: rtl/issue_scoreboard.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : issue_scoreboard                                       |
// | Stalls issue on RAW/WAW hazards or a full in-flight window and   |
// | drains outstanding writebacks on halt before parking.            |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module issue_scoreboard
  import cesel_pkg::*;
#(
  parameter  int REGFILE_ADDR_BITS = cesel_pkg::REGFILE_ADDR_BITS,
  parameter  int MAX_INFLIGHT      = 4,
  localparam int INFLIGHT_BITS     = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [REGFILE_ADDR_BITS-1:0] in_read1_addr,
  input  logic [REGFILE_ADDR_BITS-1:0] in_read2_addr,
  input  logic [REGFILE_ADDR_BITS-1:0] in_write_addr,
  input  logic                         in_write_en,
  input  logic                         in_use_immediate,
  input  logic                         in_use_accumulate,
  input  logic                         in_halt,
  output logic                         issue_valid,
  input  logic                         wb_valid,
  input  logic [REGFILE_ADDR_BITS-1:0] wb_addr,
  output logic [INFLIGHT_BITS-1:0]     inflight,
  output logic                         halted,
  output logic                         wb_error
);

  localparam int                     c_NUM_REGS = 2 ** REGFILE_ADDR_BITS;
  localparam logic [INFLIGHT_BITS-1:0] c_MAX    = INFLIGHT_BITS'(MAX_INFLIGHT);

  sched_state_e              r_state, w_state_next;
  logic [c_NUM_REGS-1:0]     r_pending, w_pending_next;
  logic [INFLIGHT_BITS-1:0]  r_inflight, w_inflight_next;
  logic                      r_wb_error, w_wb_error_next;

  logic w_raw, w_waw, w_full, w_accept, w_retire, w_wb_underflow;

  // Hazards look only at registered pending bits; a same-cycle wb does not bypass.
  always_comb begin
    w_raw    = (!in_use_immediate && (r_pending[in_read1_addr] || r_pending[in_read2_addr]))
             || (in_use_accumulate && r_pending[in_write_addr]);
    w_waw    = in_write_en && r_pending[in_write_addr];
    w_full   = (r_inflight == c_MAX);
    in_ready = (r_state == RUN) && (in_halt || !(w_raw || w_waw || w_full));
    w_accept = in_valid && in_ready;
    issue_valid = w_accept && !in_halt;
  end

  always_comb begin
    w_wb_underflow  = wb_valid && (r_inflight == '0);
    w_retire        = wb_valid && (r_inflight != '0);
    w_wb_error_next = r_wb_error || w_wb_underflow;

    w_inflight_next = r_inflight;
    if (issue_valid && !w_retire) begin
      w_inflight_next = r_inflight + 1'b1;
    end else if (!issue_valid && w_retire) begin
      w_inflight_next = r_inflight - 1'b1;
    end

    // WAW blocks issue, so a clear and a set never target the same bit.
    w_pending_next = r_pending;
    if (wb_valid) begin
      w_pending_next[wb_addr] = 1'b0;
    end
    if (issue_valid && in_write_en) begin
      w_pending_next[in_write_addr] = 1'b1;
    end

    w_state_next = r_state;
    case (r_state)
      RUN:     if (w_accept && in_halt) w_state_next = DRAIN;
      DRAIN:   if (w_inflight_next == '0) w_state_next = HALTED;
      HALTED:  w_state_next = HALTED;
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= RUN;
      r_pending  <= '0;
      r_inflight <= '0;
      r_wb_error <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pending  <= w_pending_next;
      r_inflight <= w_inflight_next;
      r_wb_error <= w_wb_error_next;
    end
  end

  assign inflight = r_inflight;
  assign halted   = (r_state == HALTED);
  assign wb_error = r_wb_error;

endmodule : issue_scoreboard
`default_nettype wire
